coredma_fifo_ctrl: RTL
======================

Name: coredma_fifo_ctrl

Overview:
- Sequencing controller for the DMA FIFO SRAM wrapper, which has a 2-cycle registered read.
- Turns the raw RAM port (WEN/WADDR/WDATA, REN/RADDR/RDATA) into a valid/ready push/pop FIFO.
- Manages circular pointers and occupancy, and prefetches RAM reads into a 3-entry output buffer so pop throughput is one word per cycle.
- Sits between the DMA write engine (push side) and the AXI/AHB master read-out engine (pop side).

Parameters:
- WIDTH, 128, data word width.
- DEPTH, 128, RAM entries; power of two, at least 4.
- AWIDTH, 7, RAM address width; log2(DEPTH).
- RD_LAT, 2, RAM read latency in cycles; fixed at 2, other values unsupported.

Ports:
- CLOCK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous clear; discards all stored and in-flight data.
- PUSH_VALID  in  1  write request.
- PUSH_DATA  in  WIDTH  write word.
- PUSH_READY  out  1  accept; a push occurs when PUSH_VALID && PUSH_READY.
- POP_VALID  out  1  head word available.
- POP_DATA  out  WIDTH  head word.
- POP_READY  in  1  consumer accept; a pop occurs when POP_VALID && POP_READY.
- LEVEL  out  AWIDTH+3  total words held (RAM + in-flight + output buffer).
- EMPTY  out  1  LEVEL==0.
- RAM_WEN  out  1  to wrapper WEN.
- RAM_WADDR  out  AWIDTH  to wrapper WADDR.
- RAM_WDATA  out  WIDTH  to wrapper WDATA.
- RAM_REN  out  1  to wrapper REN (block enable); asserted only on read issue.
- RAM_RADDR  out  AWIDTH  to wrapper RADDR.
- RAM_RDATA  in  WIDTH  from wrapper RDATA; valid RD_LAT cycles after RAM_REN.

Behaviour:
- Reset (RESET_N low, async) clears:
  - wr_ptr, rd_ptr, ram_cnt, the in-flight valid shift register, and the output buffer.
  - Output values: PUSH_READY=1, POP_VALID=0, LEVEL=0, EMPTY=1, RAM_WEN=0, RAM_REN=0, RAM_WADDR=0, RAM_RADDR=0.
  - POP_DATA and RAM_WDATA are don't-care.
- Write path, combinational:
  - RAM_WEN = PUSH_VALID && PUSH_READY; RAM_WADDR = wr_ptr; RAM_WDATA = PUSH_DATA.
  - wr_ptr increments mod DEPTH on each push.
- ram_cnt counts words written but not yet read-issued, range 0..DEPTH.
- infl counts set bits of a 2-stage read-valid shift register, range 0..2.
- PUSH_READY = (ram_cnt + infl) < DEPTH; a RAM slot is freed only once its read has returned.
- ob_cnt is output buffer occupancy, range 0..3.
- Read issue, combinational:
  - issue = (ram_cnt > 0) && (ob_cnt + infl − pop < 3), where pop is the current-cycle pop handshake.
  - RAM_REN = issue; RAM_RADDR = rd_ptr; rd_ptr increments mod DEPTH on issue.
- ram_cnt next = ram_cnt + push − issue. A word written in cycle t is read-issuable no earlier than t+1, so a write and a read to the same address never occur in the same cycle.
- Return path:
  - The shift register carries issue; its stage-2 output marks RAM_RDATA valid.
  - On that cycle RAM_RDATA is written into the output buffer tail.
  - The output buffer never overflows, by construction of the credit check.
- Output buffer is a 3-entry circular FIFO:
  - POP_VALID = ob_cnt > 0; POP_DATA = head entry, direct from a register with no RAM path.
  - Simultaneous capture and pop are allowed.
- Latency:
  - Push in cycle t into an empty FIFO gives RAM_REN at t+1, RDATA at t+3, and POP_VALID high at t+4.
  - Sustained throughput is 1 push and 1 pop per cycle with POP_READY held high.
- LEVEL = ram_cnt + infl + ob_cnt; maximum DEPTH+3. LEVEL updates the cycle after each handshake.
- FLUSH, sampled at the clock edge:
  - Next state equals the reset state, and the push/pop handshakes in that cycle are ignored.
  - Data returning from reads issued before FLUSH is discarded, because its valid bits are cleared.
  - PUSH_READY and POP_READY are honoured again from the next cycle.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no gap; full RAM with wr_ptr == rd_ptr is legal.
- Push when not ready: no state change. Pop when empty: no state change.

Test Plan:
- Reset, then one push of 0xA5 in cycle 0 → RAM_REN in cycle 1 with RADDR=0; POP_VALID in cycle 4 with POP_DATA=0xA5; LEVEL steps 0→1→0 after the pop.
- Stream 1000 incrementing words with POP_READY=1 and PUSH_VALID=1 → after the initial 4-cycle fill, one pop per cycle with no bubbles; data is in order; pointers wrap 7 times; LEVEL holds at ≤ 4.
- POP_READY=0, push until PUSH_READY drops → PUSH_READY low at LEVEL=131 (128 RAM + 3 output buffer); RAM_WEN never asserts while full; then pop all 131 words in order, with EMPTY=1 at the end.
- Random PUSH_VALID and POP_READY at 50% for 10k cycles against a scoreboard → no loss or duplication, LEVEL always matches the model, and the output buffer never holds more than 3 entries.
- FLUSH asserted the cycle after 2 reads are issued with 5 words stored → next cycle LEVEL=0 and POP_VALID=0; the stale RDATA returning 1–2 cycles later is not captured; a new push of 0x11 pops as 0x11.
- RESET_N asserted asynchronously mid-stream, between clock edges → outputs go to their reset values immediately; after release, a push/pop sequence behaves as from cold reset with RADDR starting at 0.

Source files
------------

// File: rtl/coredma_fifo_ctrl.sv
// coredma_fifo_ctrl: valid/ready FIFO sequencer around a 2-cycle registered-read SRAM wrapper.
// RAM reads are prefetched into a 3-entry output buffer so pops sustain one word per cycle.
module coredma_fifo_ctrl #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 128,
  parameter int AWIDTH = 7,
  parameter int RD_LAT = 2
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              FLUSH,
  input  logic              PUSH_VALID,
  input  logic [WIDTH-1:0]  PUSH_DATA,
  output logic              PUSH_READY,
  output logic              POP_VALID,
  output logic [WIDTH-1:0]  POP_DATA,
  input  logic              POP_READY,
  output logic [AWIDTH+2:0] LEVEL,
  output logic              EMPTY,
  output logic              RAM_WEN,
  output logic [AWIDTH-1:0] RAM_WADDR,
  output logic [WIDTH-1:0]  RAM_WDATA,
  output logic              RAM_REN,
  output logic [AWIDTH-1:0] RAM_RADDR,
  input  logic [WIDTH-1:0]  RAM_RDATA
);
  localparam int CW = AWIDTH + 1;
  localparam int LW = AWIDTH + 3;

  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [CW-1:0]     ram_cnt;
  logic [RD_LAT-1:0] rd_vld_sr;
  logic [1:0]        infl;
  logic [WIDTH-1:0]  ob_mem [3];
  logic [1:0]        ob_head;
  logic [1:0]        ob_tail;
  logic [1:0]        ob_cnt;
  logic              push;
  logic              pop;
  logic              issue;
  logic              ret;
  logic [2:0]        ob_credit;

  function automatic logic [1:0] ob_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) infl = infl + 2'(rd_vld_sr[i]);
  end

  assign ret        = rd_vld_sr[RD_LAT-1];
  // RAM slots stay reserved until their read data has come back
  assign PUSH_READY = (LW'(ram_cnt) + LW'(infl)) < LW'(DEPTH);
  assign push       = PUSH_VALID && PUSH_READY;
  assign POP_VALID  = ob_cnt != 2'd0;
  assign pop        = POP_VALID && POP_READY;
  assign ob_credit  = 3'(ob_cnt) + 3'(infl) - 3'(pop);
  assign issue      = (ram_cnt != '0) && (ob_credit < 3'd3);

  assign RAM_WEN   = push;
  assign RAM_WADDR = wr_ptr;
  assign RAM_WDATA = PUSH_DATA;
  assign RAM_REN   = issue;
  assign RAM_RADDR = rd_ptr;
  assign POP_DATA  = ob_mem[ob_head];
  assign LEVEL     = LW'(ram_cnt) + LW'(infl) + LW'(ob_cnt);
  assign EMPTY     = LEVEL == '0;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      rd_vld_sr <= '0;
      ob_head   <= '0;
      ob_tail   <= '0;
      ob_cnt    <= '0;
    end else if (FLUSH) begin
      // Clearing the valid shift register drops any read data still in flight
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      rd_vld_sr <= '0;
      ob_head   <= '0;
      ob_tail   <= '0;
      ob_cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AWIDTH'(1);
      if (issue) rd_ptr <= rd_ptr + AWIDTH'(1);
      ram_cnt   <= ram_cnt + CW'(push) - CW'(issue);
      rd_vld_sr <= {rd_vld_sr[RD_LAT-2:0], issue};
      if (ret) ob_tail <= ob_inc(ob_tail);
      if (pop) ob_head <= ob_inc(ob_head);
      ob_cnt    <= ob_cnt + 2'(ret) - 2'(pop);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (ret && !FLUSH) ob_mem[ob_tail] <= RAM_RDATA;
  end

endmodule
